// File: rtl/seq_pkg.sv
// Shared definitions for the instruction fetch sequencer.
// Holds the sequencer state encoding, the 3-bit opcode values taken from
// ir[8:6], and a helper that identifies the skipped (NOP) opcodes.
package seq_pkg;

  typedef enum logic [3:0] {
    IDLE,
    FETCH,
    CAPTURE,
    DECODE,
    FETCH_IMM,
    CAPTURE_IMM,
    ISSUE,
    EXEC,
    HALTED,
    ERROR
  } state_e;

  localparam logic [2:0] OP_MV   = 3'b000;
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_HALT = 3'b111;

  // 100..110 are never issued to the datapath.
  function automatic logic is_nop(input logic [2:0] op);
    return op[2] && (op != OP_HALT);
  endfunction

endpackage

// File: rtl/seq_watchdog.sv
// Done-timeout watchdog for the EXEC state.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   clr       - zero the count (issued instruction starts a new wait)
//   en        - one more cycle spent waiting for done
//   expired   - this enabled cycle is the TMO-th waiting cycle
module seq_watchdog #(
  parameter int unsigned TMO = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CW = $clog2(TMO);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Expiry is flagged on the cycle whose increment would bring the count to
  // TMO, so the sequencer leaves EXEC after exactly TMO waiting cycles.
  always_comb begin
    expired = en && (count_q == CW'(TMO - 1));
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && !expired) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/instr_fetch_sequencer.sv
// Multi-cycle instruction fetch sequencer for the control unit datapath.
// Fetches instructions from a synchronous ROM, fetches the immediate word for
// mvi, loads IR, pulses run and waits for done with a timeout watchdog.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   start             - begin execution at PC 0 (IDLE only)
//   mem_addr, mem_rd  - ROM address / read strobe (data next cycle)
//   mem_rdata         - ROM read data
//   ir_out, ir_load   - instruction word and its one-cycle load strobe
//   run, done_in      - issue pulse to / completion from the control unit
//   din_out           - zero-extended mvi immediate
//   pc_out            - program counter
//   busy, halted, error - status
module instr_fetch_sequencer
  import seq_pkg::*;
#(
  parameter int unsigned AW  = 5,
  parameter int unsigned IW  = 9,
  parameter int unsigned DW  = 32,
  parameter int unsigned TMO = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic [AW-1:0] mem_addr,
  output logic          mem_rd,
  input  logic [IW-1:0] mem_rdata,
  output logic [IW-1:0] ir_out,
  output logic          ir_load,
  output logic          run,
  input  logic          done_in,
  output logic [DW-1:0] din_out,
  output logic [AW-1:0] pc_out,
  output logic          busy,
  output logic          halted,
  output logic          error
);

  state_e        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [IW-1:0] ir_q, ir_d;
  logic [DW-1:0] din_q, din_d;
  logic [2:0]    opcode;
  logic          wd_clr;
  logic          wd_en;
  logic          wd_expired;

  assign opcode = ir_q[IW-1 -: 3];
  assign wd_clr = (state_q == ISSUE);
  assign wd_en  = (state_q == EXEC) && !done_in;

  seq_watchdog #(
    .TMO(TMO)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clr    (wd_clr),
    .en     (wd_en),
    .expired(wd_expired)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    din_d   = din_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          pc_d    = '0;
          state_d = FETCH;
        end
      end
      FETCH:   state_d = CAPTURE;
      CAPTURE: begin
        ir_d    = mem_rdata;
        state_d = DECODE;
      end
      DECODE: begin
        if (opcode == OP_HALT) begin
          state_d = HALTED;
        end else if (is_nop(opcode)) begin
          pc_d    = pc_q + 1'b1;
          state_d = FETCH;
        end else if (opcode == OP_MVI) begin
          pc_d    = pc_q + 1'b1;
          state_d = FETCH_IMM;
        end else begin
          pc_d    = pc_q + 1'b1;
          state_d = ISSUE;
        end
      end
      FETCH_IMM: state_d = CAPTURE_IMM;
      CAPTURE_IMM: begin
        din_d   = DW'(mem_rdata);
        pc_d    = pc_q + 1'b1;
        state_d = ISSUE;
      end
      ISSUE: state_d = EXEC;
      EXEC: begin
        // done has priority over a simultaneous timeout.
        if (done_in) begin
          state_d = FETCH;
        end else if (wd_expired) begin
          state_d = ERROR;
        end
      end
      HALTED:  state_d = HALTED;
      ERROR:   state_d = ERROR;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      din_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      din_q   <= din_d;
    end
  end

  always_comb begin
    mem_addr = pc_q;
    mem_rd   = (state_q == FETCH) || (state_q == FETCH_IMM);
    ir_load  = (state_q == ISSUE);
    run      = (state_q == ISSUE);
    ir_out   = ir_q;
    din_out  = din_q;
    pc_out   = pc_q;
    busy     = (state_q != IDLE) && (state_q != HALTED) && (state_q != ERROR);
    halted   = (state_q == HALTED);
    error    = (state_q == ERROR);
  end

endmodule

// File: tb/tb_instr_fetch_sequencer.sv
// Self-checking bench for instr_fetch_sequencer: a ROM model, a done responder
// and a scoreboard of expected run pulses (IR, DIN, PC, cycle gap).
module tb_instr_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [4:0]  mem_addr;
  logic        mem_rd;
  logic [8:0]  mem_rdata;
  logic [8:0]  ir_out;
  logic        ir_load;
  logic        run;
  logic        done_in;
  logic [31:0] din_out;
  logic [4:0]  pc_out;
  logic        busy;
  logic        halted;
  logic        error;

  localparam logic [8:0] I_HALT = 9'b111_000_000;
  localparam logic [8:0] I_NOP6 = 9'b110_000_000;
  localparam logic [8:0] I_NOP5 = 9'b101_000_000;

  typedef struct {
    logic [8:0]  ir;
    logic [31:0] din;
    logic [4:0]  pc;
    int          gap;
  } exp_t;

  exp_t       sb[$];
  logic [8:0] rom[32];
  int         n_checks = 0;
  int         n_pass = 0;
  int         cyc = 0;
  int         last_ref = 0;
  int         last_run_cyc = 0;
  int         done_delay = 1;
  bit         done_force = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (mem_rd) mem_rdata <= rom[mem_addr];
  end

  instr_fetch_sequencer #(
    .AW (5),
    .IW (9),
    .DW (32),
    .TMO(8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .mem_addr (mem_addr),
    .mem_rd   (mem_rd),
    .mem_rdata(mem_rdata),
    .ir_out   (ir_out),
    .ir_load  (ir_load),
    .run      (run),
    .done_in  (done_in),
    .din_out  (din_out),
    .pc_out   (pc_out),
    .busy     (busy),
    .halted   (halted),
    .error    (error)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end else begin
      n_pass++;
    end
  endtask

  // done_in rises in the done_delay-th EXEC cycle after a run pulse (0 = never).
  initial begin
    int cd;
    cd = 0;
    done_in = 1'b0;
    forever begin
      @(negedge clk);
      done_in = done_force;
      if (rst) begin
        cd = 0;
      end else begin
        if (cd > 0) begin
          cd--;
          if (cd == 0) done_in = 1'b1;
        end
        if (run && done_delay > 0) cd = done_delay;
      end
    end
  end

  // Scoreboard consumer: every run pulse must match the next expected issue.
  initial begin
    forever begin
      @(negedge clk);
      if (run === 1'b1) begin
        exp_t e;
        if (sb.size() == 0) begin
          check_eq("run_unexpected", 32'(run), 32'd0);
        end else begin
          e = sb.pop_front();
          check_eq("run_ir", 32'(ir_out), 32'(e.ir));
          check_eq("run_din", din_out, e.din);
          check_eq("run_pc", 32'(pc_out), 32'(e.pc));
          check_eq("run_ir_load", 32'(ir_load), 32'd1);
          check_eq("run_gap", 32'(cyc - last_ref), 32'(e.gap));
        end
        last_ref = cyc;
        last_run_cyc = cyc;
      end
    end
  end

  task automatic push_exp(input logic [8:0] ir, input logic [31:0] din,
                          input logic [4:0] pc, input int gap);
    exp_t e;
    e.ir = ir;
    e.din = din;
    e.pc = pc;
    e.gap = gap;
    sb.push_back(e);
  endtask

  task automatic rom_fill(input logic [8:0] v);
    for (int i = 0; i < 32; i++) rom[i] = v;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    last_ref = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
    check_eq({tag, "_halted"}, 32'(halted), 32'd0);
    check_eq({tag, "_error"}, 32'(error), 32'd0);
    check_eq({tag, "_pc"}, 32'(pc_out), 32'd0);
    check_eq({tag, "_addr"}, 32'(mem_addr), 32'd0);
    check_eq({tag, "_strobes"}, {29'd0, mem_rd, ir_load, run}, 32'd0);
    check_eq({tag, "_ir"}, 32'(ir_out), 32'd0);
    check_eq({tag, "_din"}, din_out, 32'd0);
  endtask

  task automatic wait_halted(input string tag, input int budget, input logic [4:0] pc);
    for (int i = 0; i < budget && halted !== 1'b1; i++) @(negedge clk);
    check_eq({tag, "_halted"}, 32'(halted), 32'd1);
    check_eq({tag, "_halt_pc"}, 32'(pc_out), 32'(pc));
    check_eq({tag, "_halt_err"}, 32'(error), 32'd0);
    check_eq({tag, "_halt_busy"}, 32'(busy), 32'd0);
    check_eq({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    start = 1'b0;
    rom_fill(I_HALT);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_reset("por");

    // Straight-line: mv, add, HALT.
    rom_fill(I_HALT);
    rom[0] = 9'b000_001_010;
    rom[1] = 9'b010_000_001;
    done_delay = 1;
    push_exp(9'h00A, 32'd0, 5'd1, 4);
    push_exp(9'h081, 32'd0, 5'd2, 5);
    pulse_start();
    wait_halted("line", 60, 5'd2);
    check_eq("line_halt_strobes", {30'd0, mem_rd, run}, 32'd0);
    pulse_start();
    repeat (3) @(negedge clk);
    check_eq("line_start_ignored", {30'd0, halted, busy}, 32'd2);
    do_reset();

    // mvi with immediate.
    rom_fill(I_HALT);
    rom[0] = 9'b001_011_000;
    rom[1] = 9'h1A5;
    push_exp(9'h058, 32'h0000_01A5, 5'd2, 6);
    pulse_start();
    wait_halted("mvi", 60, 5'd2);
    check_eq("mvi_din_hold", din_out, 32'h0000_01A5);
    do_reset();

    // NOP skipping.
    rom_fill(I_HALT);
    rom[0] = I_NOP6;
    rom[1] = 9'b011_010_001;
    push_exp(9'h0D1, 32'd0, 5'd2, 7);
    pulse_start();
    wait_halted("nop", 60, 5'd2);
    do_reset();

    // Watchdog timeout, sticky ERROR.
    rom_fill(I_HALT);
    rom[0] = 9'b010_000_001;
    done_delay = 0;
    push_exp(9'h081, 32'd0, 5'd1, 4);
    pulse_start();
    for (int i = 0; i < 60 && error !== 1'b1; i++) @(negedge clk);
    check_eq("wd_error", 32'(error), 32'd1);
    check_eq("wd_latency", 32'(cyc - last_run_cyc), 32'd9);
    check_eq("wd_busy", 32'(busy), 32'd0);
    done_force = 1'b1;
    repeat (3) @(negedge clk);
    done_force = 1'b0;
    pulse_start();
    repeat (3) @(negedge clk);
    check_eq("wd_sticky", 32'(error), 32'd1);
    check_eq("wd_pc_hold", 32'(pc_out), 32'd1);
    check_eq("wd_strobes", {30'd0, mem_rd, run}, 32'd0);
    do_reset();
    check_reset("wd_rst");

    // Reset while in EXEC.
    rom_fill(I_HALT);
    rom[0] = 9'b010_000_001;
    push_exp(9'h081, 32'd0, 5'd1, 4);
    pulse_start();
    repeat (5) @(negedge clk);
    check_eq("mid_exec_busy", 32'(busy), 32'd1);
    check_eq("mid_exec_sb", 32'(sb.size()), 32'd0);
    do_reset();
    check_reset("mid_exec");
    // The captured IR must also have been cleared.
    check_eq("mid_exec_ir_clr", 32'(ir_out), 32'd0);

    // done_in on the cycle the watchdog would expire: done wins.
    rom_fill(I_HALT);
    rom[0] = 9'b010_000_001;
    done_delay = 8;
    push_exp(9'h081, 32'd0, 5'd1, 4);
    pulse_start();
    wait_halted("tmo_edge", 60, 5'd1);
    do_reset();

    // PC wrap: mvi at 31 fetches its immediate from address 0.
    done_delay = 1;
    rom_fill(I_NOP6);
    rom[0] = I_NOP5;
    rom[1] = 9'b011_010_001;
    rom[31] = 9'b001_010_000;
    push_exp(9'h0D1, 32'd0, 5'd2, 7);
    push_exp(9'h050, 32'h0000_0140, 5'd1, 94);
    push_exp(9'h0D1, 32'h0000_0140, 5'd2, 5);
    pulse_start();
    for (int i = 0; i < 300 && sb.size() != 0; i++) @(negedge clk);
    check_eq("wrap_sb_empty", 32'(sb.size()), 32'd0);
    check_eq("wrap_busy", 32'(busy), 32'd1);
    do_reset();
    check_reset("final");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
